// File: rtl/kernel_weight_loader_pkg.sv
// kernel_weight_loader_pkg: kernel-load constants and loader state codes
package kernel_weight_loader_pkg;
   localparam int KW_TAPS        = 9;
   localparam int KW_NUM_KERNELS = 4;
   localparam int KW_WORDS       = KW_TAPS * KW_NUM_KERNELS;
   localparam int KW_DATA_W      = 16;
   typedef logic [1:0] kw_state_t;
   localparam kw_state_t KW_IDLE  = 2'd0;
   localparam kw_state_t KW_ISSUE = 2'd1;
   localparam kw_state_t KW_DRAIN = 2'd2;
   localparam kw_state_t KW_DONE  = 2'd3;
endpackage

// File: rtl/kernel_weight_loader.sv
// kernel_weight_loader: streams one kernel set from the weight ROM into the kernel shift buffer
module kernel_weight_loader
   import kernel_weight_loader_pkg::*;
#(
   parameter int DATA_W      = KW_DATA_W,
   parameter int ADDR_W      = 16,
   parameter int TAPS        = KW_TAPS,
   parameter int NUM_KERNELS = KW_NUM_KERNELS
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [ADDR_W-1:0]        base_addr,
   input  logic                     pause,
   output logic                     rom_en,
   output logic [ADDR_W-1:0]        rom_addr,
   input  logic signed [DATA_W-1:0] rom_data,
   output logic                     pe_ready,
   output logic signed [DATA_W-1:0] kernal,
   output logic                     busy,
   output logic                     done
);
   localparam int WORDS = TAPS * NUM_KERNELS;
   localparam int CNT_W = $clog2(WORDS);
   kw_state_t                 state_q, state_d;
   logic [CNT_W-1:0]          cnt_q, cnt_d;
   logic [ADDR_W-1:0]         base_q, base_d;
   logic [1:0]                drain_q, drain_d;
   logic                      rd_valid_q, rd_valid_d;
   logic                      pe_ready_q, pe_ready_d;
   logic signed [DATA_W-1:0]  kernal_q, kernal_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= KW_IDLE;
         cnt_q      <= '0;
         base_q     <= '0;
         drain_q    <= '0;
         rd_valid_q <= 1'b0;
         pe_ready_q <= 1'b0;
         kernal_q   <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         base_q     <= base_d;
         drain_q    <= drain_d;
         rd_valid_q <= rd_valid_d;
         pe_ready_q <= pe_ready_d;
         kernal_q   <= kernal_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      base_d     = base_q;
      drain_d    = drain_q;
      case (state_q)
         KW_IDLE: begin
            cnt_d = '0;
            if (start) begin
               state_d = KW_ISSUE;
               base_d  = base_addr;
            end
         end
         KW_ISSUE: if (!pause) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WORDS - 1)) begin
               state_d = KW_DRAIN;
               drain_d = '0;
            end
         end
         KW_DRAIN: begin
            drain_d = drain_q + 2'd1;
            state_d = drain_q == 2'd2 ? KW_DONE : KW_DRAIN;
         end
         default: state_d = KW_IDLE;
      endcase
      // two-stage read pipeline: ROM latency, then output register
      rd_valid_d = rom_en;
      pe_ready_d = rd_valid_q;
      kernal_d   = rd_valid_q ? rom_data : kernal_q;
   end

   always_comb begin
      rom_en   = state_q == KW_ISSUE && !pause;
      rom_addr = rom_en ? base_q + ADDR_W'(cnt_q) : '0;
      busy     = state_q != KW_IDLE;
      done     = state_q == KW_DONE;
      pe_ready = pe_ready_q;
      kernal   = kernal_q;
   end
endmodule
